// File: rtl/tape_buffer_ctrl_if.sv
// Tape port between the tape buffer client and the SDRAM controller.
// The client (master) drives address, write data and the level requests;
// the controller (slave) returns read data and toggles ack once per access.
interface tape_buffer_ctrl_if #(
   parameter int ADDR_W = 23
);
   logic [ADDR_W-1:0] tape_addr;
   logic [7:0]        tape_din;
   logic [7:0]        tape_dout;
   logic              tape_wr;
   logic              tape_rd;
   logic              tape_ack;

   modport master (
      output tape_addr, tape_din, tape_wr, tape_rd,
      input  tape_dout, tape_ack
   );

   modport slave (
      input  tape_addr, tape_din, tape_wr, tape_rd,
      output tape_dout, tape_ack
   );
endinterface

// File: rtl/tape_buffer_ctrl.sv
// Tape buffer client for the SDRAM controller tape port.
// Downloaded bytes pass through a small FIFO and are written to SDRAM at
// sequential addresses from 0. Playback prefetches one byte at a time into
// play_data; play_rd consumes it, play_rewind restarts at address 0.
// The top byte address is never written, so tape_len cannot wrap to 0;
// bytes arriving once the address space is used up are dropped and flagged.
module tape_buffer_ctrl #(
   parameter int ADDR_W     = 23,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [7:0]        dl_data,
   output logic              dl_full,
   output logic              dl_overflow,
   input  logic              play_rewind,
   input  logic              play_rd,
   output logic [7:0]        play_data,
   output logic              play_valid,
   output logic              play_eof,
   output logic [ADDR_W-1:0] tape_len,
   tape_buffer_ctrl_if.master tape
);

   localparam int IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = IW + 1;
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_t;

   state_t            state_r;
   logic              ack_ref_r;
   logic              discard_r;
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [ADDR_W-1:0] tape_len_r;
   logic [ADDR_W-1:0] tape_addr_r;
   logic [7:0]        tape_din_r;
   logic [7:0]        play_data_r;
   logic              play_valid_r;
   logic              play_eof_r;
   logic              dl_active_d_r;
   logic              dl_full_r;
   logic              dl_overflow_r;

   logic [7:0]        fifo_mem_r [FIFO_DEPTH];
   logic [IW-1:0]     fifo_rd_idx_r;
   logic [IW-1:0]     fifo_wr_idx_r;
   logic [CW-1:0]     fifo_cnt_r;
   logic [CW-1:0]     fifo_cnt_nxt_s;

   logic              start_s;
   logic              ack_seen_s;
   logic              wr_done_s;
   logic              rd_done_s;
   logic              fifo_empty_s;
   logic              addr_full_s;
   logic              exhaust_s;
   logic              push_s;
   logic              pop_s;
   logic              rd_req_ok_s;

   // Event decode: download start, access completion, FIFO push/pop.
   always_comb begin
      start_s      = dl_active & ~dl_active_d_r;
      ack_seen_s   = tape.tape_ack ^ ack_ref_r;
      wr_done_s    = (state_r == ST_WR) & ack_seen_s;
      rd_done_s    = (state_r == ST_RD) & ack_seen_s;
      fifo_empty_s = (fifo_cnt_r == {CW{1'b0}});
      addr_full_s  = (wr_ptr_r == ADDR_MAX);
      exhaust_s    = (state_r == ST_IDLE) & ~start_s & ~fifo_empty_s & addr_full_s;
      pop_s        = ~start_s & ((wr_done_s & ~discard_r) | exhaust_s);
      rd_req_ok_s  = ~dl_active & ~play_valid_r & (rd_ptr_r < tape_len_r);
      if (start_s) begin
         push_s         = dl_wr;
         fifo_cnt_nxt_s = {{(CW-1){1'b0}}, dl_wr};
      end else begin
         push_s         = dl_wr & (~dl_full_r | pop_s);
         fifo_cnt_nxt_s = fifo_cnt_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Download FIFO storage and pointers; cleared at download start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_rd_idx_r <= '0;
         fifo_wr_idx_r <= '0;
         fifo_cnt_r    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= 8'h00;
         end
      end else begin
         if (start_s) begin
            fifo_rd_idx_r <= '0;
            fifo_wr_idx_r <= dl_wr ? IW'(1) : {IW{1'b0}};
            if (dl_wr) begin
               fifo_mem_r[0] <= dl_data;
            end
         end else begin
            if (push_s) begin
               fifo_mem_r[fifo_wr_idx_r] <= dl_data;
               fifo_wr_idx_r             <= fifo_wr_idx_r + IW'(1);
            end
            if (pop_s) begin
               fifo_rd_idx_r <= fifo_rd_idx_r + IW'(1);
            end
         end
         fifo_cnt_r <= fifo_cnt_nxt_s;
      end
   end

   // Access sequencer: issues SDRAM writes (priority) and prefetch reads,
   // tracks the ack toggle and commits completed writes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         ack_ref_r   <= tape.tape_ack;
         discard_r   <= 1'b0;
         wr_ptr_r    <= '0;
         tape_len_r  <= '0;
         tape_addr_r <= '0;
         tape_din_r  <= 8'h00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ack_ref_r <= tape.tape_ack;
               discard_r <= 1'b0;
               if (start_s) begin
                  state_r <= ST_IDLE;
               end else if (!fifo_empty_s) begin
                  if (!addr_full_s) begin
                     state_r     <= ST_WR;
                     tape_addr_r <= wr_ptr_r;
                     tape_din_r  <= fifo_mem_r[fifo_rd_idx_r];
                  end
               end else if (rd_req_ok_s) begin
                  state_r     <= ST_RD;
                  tape_addr_r <= rd_ptr_r;
                  discard_r   <= play_rewind;
               end
            end
            ST_WR, ST_RD: begin
               if (ack_seen_s) begin
                  ack_ref_r <= tape.tape_ack;
                  state_r   <= ST_IDLE;
                  discard_r <= 1'b0;
                  if (wr_done_s && !discard_r) begin
                     wr_ptr_r   <= wr_ptr_r + ADDR_ONE;
                     tape_len_r <= wr_ptr_r + ADDR_ONE;
                  end
               end else begin
                  discard_r <= discard_r | start_s |
                               ((state_r == ST_RD) & play_rewind);
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               ack_ref_r <= tape.tape_ack;
               discard_r <= 1'b0;
            end
         endcase
         if (start_s) begin
            wr_ptr_r   <= '0;
            tape_len_r <= '0;
         end
      end
   end

   // Playback prefetch register, read pointer and end-of-tape flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_r     <= '0;
         play_data_r  <= 8'h00;
         play_valid_r <= 1'b0;
         play_eof_r   <= 1'b1;
      end else begin
         if (start_s || play_rewind) begin
            rd_ptr_r     <= '0;
            play_valid_r <= 1'b0;
         end else if (rd_done_s && !discard_r) begin
            play_data_r  <= tape.tape_dout;
            play_valid_r <= 1'b1;
         end else if (play_rd && play_valid_r) begin
            play_valid_r <= 1'b0;
            rd_ptr_r     <= rd_ptr_r + ADDR_ONE;
         end
         play_eof_r <= ~dl_active & ~play_valid_r & (rd_ptr_r >= tape_len_r);
      end
   end

   // Download status flags and the dl_active edge detector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dl_active_d_r <= 1'b0;
         dl_full_r     <= 1'b0;
         dl_overflow_r <= 1'b0;
      end else begin
         dl_active_d_r <= dl_active;
         dl_full_r     <= (fifo_cnt_nxt_s == CW'(FIFO_DEPTH));
         if (start_s) begin
            dl_overflow_r <= 1'b0;
         end else if ((dl_wr && !push_s) || exhaust_s) begin
            dl_overflow_r <= 1'b1;
         end
      end
   end

   // Requests drop combinationally in the cycle the ack toggle is seen.
   assign tape.tape_wr   = (state_r == ST_WR) & ~ack_seen_s;
   assign tape.tape_rd   = (state_r == ST_RD) & ~ack_seen_s;
   assign tape.tape_addr = tape_addr_r;
   assign tape.tape_din  = tape_din_r;

   assign dl_full     = dl_full_r;
   assign dl_overflow = dl_overflow_r;
   assign play_data   = play_data_r;
   assign play_valid  = play_valid_r;
   assign play_eof    = play_eof_r;
   assign tape_len    = tape_len_r;

endmodule
